// File: rtl/mem_addr_gen.sv
//==============================================================================
// Module   : mem_addr_gen
// Brief    : Windowed BRAM address generator with stride, direction and wrap.
// Revision : 1.0
//==============================================================================
`default_nettype none

module mem_addr_gen #(
  parameter int MEM_SIZE = 262144,
  parameter int ADDR_W   = $clog2(MEM_SIZE),
  parameter int STRIDE_W = 8,
  parameter int CNT_W    = ADDR_W + 1
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   cfg_base,
  input  logic [ADDR_W-1:0]   cfg_limit,
  input  logic [STRIDE_W-1:0] cfg_stride,
  input  logic                cfg_wrap,
  input  logic                cfg_down,
  input  logic                start,
  input  logic                abort,
  input  logic                step_en,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                busy,
  output logic                done,
  output logic                wrap_pulse,
  output logic                cfg_err,
  output logic [CNT_W-1:0]    step_count
);

  localparam logic [ADDR_W-1:0] c_top_addr = ADDR_W'(MEM_SIZE - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_base, w_base_nxt;
  logic [ADDR_W-1:0]   r_limit, w_limit_nxt;
  logic [ADDR_W:0]     r_stride, w_stride_nxt;
  logic                r_wrap, w_wrap_nxt;
  logic                r_down, w_down_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_done, w_done_nxt;
  logic                r_wrap_pulse, w_wrap_pulse_nxt;
  logic                r_cfg_err, w_cfg_err_nxt;

  logic [ADDR_W-1:0]   w_eff_limit;
  logic [ADDR_W:0]     w_eff_stride;
  logic                w_cfg_ok;
  logic [ADDR_W:0]     w_up_sum;
  logic [ADDR_W:0]     w_dn_floor;
  logic [ADDR_W-1:0]   w_dn_next;
  logic [CNT_W-1:0]    w_cnt_inc;

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_base       <= '0;
      r_limit      <= '0;
      r_stride     <= '0;
      r_wrap       <= 1'b0;
      r_down       <= 1'b0;
      r_addr       <= '0;
      r_cnt        <= '0;
      r_done       <= 1'b0;
      r_wrap_pulse <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_base       <= w_base_nxt;
      r_limit      <= w_limit_nxt;
      r_stride     <= w_stride_nxt;
      r_wrap       <= w_wrap_nxt;
      r_down       <= w_down_nxt;
      r_addr       <= w_addr_nxt;
      r_cnt        <= w_cnt_nxt;
      r_done       <= w_done_nxt;
      r_wrap_pulse <= w_wrap_pulse_nxt;
      r_cfg_err    <= w_cfg_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_base_nxt       = r_base;
    w_limit_nxt      = r_limit;
    w_stride_nxt     = r_stride;
    w_wrap_nxt       = r_wrap;
    w_down_nxt       = r_down;
    w_addr_nxt       = r_addr;
    w_cnt_nxt        = r_cnt;
    w_done_nxt       = 1'b0;
    w_wrap_pulse_nxt = 1'b0;
    w_cfg_err_nxt    = 1'b0;

    w_eff_limit  = (cfg_limit > c_top_addr) ? c_top_addr : cfg_limit;
    w_eff_stride = (cfg_stride == '0) ? (ADDR_W+1)'(1) : (ADDR_W+1)'(cfg_stride);
    w_cfg_ok     = (cfg_base <= w_eff_limit);

    // Comparisons run one bit wider so an overshoot past the top of memory is seen.
    w_up_sum   = {1'b0, r_addr} + r_stride;
    w_dn_floor = {1'b0, r_base} + r_stride;
    w_dn_next  = r_addr - r_stride[ADDR_W-1:0];
    w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

    if (abort) begin
      w_state_nxt = S_IDLE;
    end else if (start) begin
      if (w_cfg_ok) begin
        w_state_nxt  = S_RUN;
        w_base_nxt   = cfg_base;
        w_limit_nxt  = w_eff_limit;
        w_stride_nxt = w_eff_stride;
        w_wrap_nxt   = cfg_wrap;
        w_down_nxt   = cfg_down;
        w_addr_nxt   = cfg_down ? w_eff_limit : cfg_base;
        w_cnt_nxt    = '0;
      end else begin
        w_cfg_err_nxt = 1'b1;
      end
    end else if (step_en && (r_state == S_RUN)) begin
      w_cnt_nxt = w_cnt_inc;
      if (!r_down && (w_up_sum <= {1'b0, r_limit})) begin
        w_addr_nxt = w_up_sum[ADDR_W-1:0];
      end else if (r_down && ({1'b0, r_addr} >= w_dn_floor)) begin
        w_addr_nxt = w_dn_next;
      end else if (r_wrap) begin
        w_addr_nxt       = r_down ? r_limit : r_base;
        w_wrap_pulse_nxt = 1'b1;
      end else begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
    end
  end

  assign mem_address = r_addr;
  assign busy        = (r_state == S_RUN);
  assign done        = r_done;
  assign wrap_pulse  = r_wrap_pulse;
  assign cfg_err     = r_cfg_err;
  assign step_count  = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mem_addr_gen.sv
//==============================================================================
// Module   : tb_mem_addr_gen
// Brief    : Directed and random checks of mem_addr_gen against an integer model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_mem_addr_gen;

  localparam int MEM = 1000;
  localparam int AW  = 10;
  localparam int SW  = 8;
  localparam int CW  = 11;
  localparam int CNT_MAX = 2047;

  logic          CLK = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] cfg_base = '0;
  logic [AW-1:0] cfg_limit = '0;
  logic [SW-1:0] cfg_stride = '0;
  logic          cfg_wrap = 1'b0;
  logic          cfg_down = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          step_en = 1'b0;
  logic [AW-1:0] mem_address;
  logic          busy, done, wrap_pulse, cfg_err;
  logic [CW-1:0] step_count;

  mem_addr_gen #(.MEM_SIZE(MEM), .ADDR_W(AW), .STRIDE_W(SW), .CNT_W(CW)) dut (
    .CLK(CLK), .rst(rst),
    .cfg_base(cfg_base), .cfg_limit(cfg_limit), .cfg_stride(cfg_stride),
    .cfg_wrap(cfg_wrap), .cfg_down(cfg_down),
    .start(start), .abort(abort), .step_en(step_en),
    .mem_address(mem_address), .busy(busy), .done(done),
    .wrap_pulse(wrap_pulse), .cfg_err(cfg_err), .step_count(step_count)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, plain integers.
  int m_run = 0, m_addr = 0, m_base = 0, m_lim = 0, m_st = 0;
  int m_wrap = 0, m_down = 0, m_cnt = 0;
  int e_done = 0, e_wp = 0, e_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_update();
    int lim;
    e_done = 0; e_wp = 0; e_err = 0;
    if (rst) begin
      m_run = 0; m_addr = 0; m_cnt = 0;
    end else if (abort) begin
      m_run = 0;
    end else if (start) begin
      lim = (int'(cfg_limit) > MEM - 1) ? MEM - 1 : int'(cfg_limit);
      if (int'(cfg_base) > lim) begin
        e_err = 1;
      end else begin
        m_run  = 1;
        m_base = int'(cfg_base);
        m_lim  = lim;
        m_st   = (cfg_stride == 0) ? 1 : int'(cfg_stride);
        m_wrap = int'(cfg_wrap);
        m_down = int'(cfg_down);
        m_addr = m_down ? m_lim : m_base;
        m_cnt  = 0;
      end
    end else if (step_en && m_run == 1) begin
      m_cnt = (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
      if (m_down == 0 && m_addr + m_st <= m_lim) m_addr = m_addr + m_st;
      else if (m_down == 1 && m_addr - m_st >= m_base) m_addr = m_addr - m_st;
      else if (m_wrap == 1) begin
        m_addr = m_down ? m_lim : m_base;
        e_wp = 1;
      end else begin
        e_done = 1;
        m_run = 0;
      end
    end
  endtask

  // One clock: model follows the sampled inputs, then every output is compared.
  task automatic tick();
    @(posedge CLK);
    model_update();
    #1;
    chk("mem_address", int'(mem_address), m_addr);
    chk("busy",        int'(busy),        m_run);
    chk("done",        int'(done),        e_done);
    chk("wrap_pulse",  int'(wrap_pulse),  e_wp);
    chk("cfg_err",     int'(cfg_err),     e_err);
    chk("step_count",  int'(step_count),  m_cnt);
  endtask

  task automatic drive(input logic s, input logic a, input logic e);
    start = s; abort = a; step_en = e;
    tick();
  endtask

  task automatic set_cfg(input int b, input int l, input int st, input int w, input int d);
    cfg_base = AW'(b); cfg_limit = AW'(l); cfg_stride = SW'(st);
    cfg_wrap = w[0]; cfg_down = d[0];
  endtask

  initial begin
    int wp_seen;
    int r;

    // Reset
    drive(0, 0, 0);
    drive(0, 0, 0);
    chk("lit_reset_addr", int'(mem_address), 0);
    chk("lit_reset_busy", int'(busy), 0);
    chk("lit_reset_cnt",  int'(step_count), 0);
    rst = 1'b0;

    // Full circular sweep; limit beyond memory clamps to MEM-1
    set_cfg(0, 1023, 1, 1, 0);
    drive(1, 0, 0);
    chk("lit_sweep_first", int'(mem_address), 0);
    wp_seen = 0;
    for (int i = 0; i < 999; i++) begin
      drive(0, 0, 1);
      wp_seen += int'(wrap_pulse);
    end
    chk("lit_sweep_last", int'(mem_address), 999);
    drive(0, 0, 1);
    wp_seen += int'(wrap_pulse);
    chk("lit_sweep_wrap_addr", int'(mem_address), 0);
    chk("lit_sweep_wrap_cnt",  wp_seen, 1);
    chk("lit_sweep_steps",     int'(step_count), 1000);
    for (int i = 0; i < 1100; i++) drive(0, 0, 1);
    chk("lit_cnt_saturate", int'(step_count), CNT_MAX);
    drive(0, 1, 0);

    // One-shot up, stride 8
    set_cfg(16, 40, 8, 0, 0);
    drive(1, 0, 0);
    chk("lit_os_first", int'(mem_address), 16);
    for (int i = 0; i < 3; i++) drive(0, 0, 1);
    chk("lit_os_last", int'(mem_address), 40);
    drive(0, 0, 1);
    chk("lit_os_done", int'(done), 1);
    chk("lit_os_busy", int'(busy), 0);
    chk("lit_os_hold", int'(mem_address), 40);
    chk("lit_os_cnt",  int'(step_count), 4);
    drive(0, 0, 1);

    // Circular down, stride 3
    set_cfg(10, 20, 3, 1, 1);
    drive(1, 0, 0);
    chk("lit_dn_first", int'(mem_address), 20);
    for (int i = 0; i < 3; i++) drive(0, 0, 1);
    chk("lit_dn_last", int'(mem_address), 11);
    drive(0, 0, 1);
    chk("lit_dn_wrap_addr", int'(mem_address), 20);
    chk("lit_dn_wrap_pulse", int'(wrap_pulse), 1);
    drive(0, 1, 0);

    // Rejected start
    set_cfg(100, 50, 1, 0, 0);
    drive(1, 0, 0);
    chk("lit_rej_err",  int'(cfg_err), 1);
    chk("lit_rej_busy", int'(busy), 0);
    chk("lit_rej_addr", int'(mem_address), 20);

    // Abort beats step_en, then stride 0 acts as 1
    set_cfg(16, 40, 8, 0, 0);
    drive(1, 0, 0);
    drive(0, 0, 1);
    drive(0, 1, 1);
    chk("lit_abort_addr", int'(mem_address), 24);
    chk("lit_abort_busy", int'(busy), 0);
    chk("lit_abort_done", int'(done), 0);
    set_cfg(5, 9, 0, 0, 0);
    drive(1, 0, 0);
    drive(0, 0, 1);
    drive(0, 0, 1);
    chk("lit_stride0", int'(mem_address), 7);

    // Reset mid-run
    set_cfg(16, 40, 8, 0, 0);
    drive(1, 0, 0);
    drive(0, 0, 1);
    drive(0, 0, 1);
    chk("lit_pre_rst", int'(mem_address), 32);
    rst = 1'b1;
    drive(0, 0, 1);
    rst = 1'b0;
    chk("lit_rst_addr", int'(mem_address), 0);
    chk("lit_rst_busy", int'(busy), 0);
    chk("lit_rst_cnt",  int'(step_count), 0);
    drive(1, 0, 0);
    drive(0, 0, 1);
    chk("lit_after_rst", int'(mem_address), 24);

    // Window of one address: every step wraps, or completes at once
    set_cfg(7, 7, 1, 1, 0);
    drive(1, 0, 0);
    drive(0, 0, 1);
    chk("lit_w1_wrap", int'(wrap_pulse), 1);
    drive(0, 0, 1);
    chk("lit_w1_wrap2", int'(wrap_pulse), 1);
    set_cfg(7, 7, 1, 0, 1);
    drive(1, 0, 0);
    drive(0, 0, 1);
    chk("lit_w1_done", int'(done), 1);

    // Random traffic, including mid-run cfg changes, big strides and clamped limits
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 80) set_cfg(int'($urandom_range(0, 990)), 0, 0, 0, 0);
      else        set_cfg(int'($urandom_range(0, 1023)), 0, 0, 0, 0);
      r = int'($urandom_range(0, 99));
      if (r < 80) cfg_limit = AW'(int'(cfg_base) + int'($urandom_range(0, 40)));
      else        cfg_limit = AW'($urandom_range(0, 1023));
      r = int'($urandom_range(0, 99));
      cfg_stride = (r < 85) ? SW'($urandom_range(0, 12)) : SW'($urandom_range(0, 255));
      cfg_wrap = 1'($urandom_range(0, 1));
      cfg_down = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 199) == 0);
      r = int'($urandom_range(0, 99));
      drive(r < 6, (r >= 6 && r < 9), ($urandom_range(0, 99) < 65));
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
